// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store with a fixed-latency access sequencer.
// Optional statistics counters are enabled by defining MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_pipe
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]   stat_if_grants,
  output logic [31:0]   stat_dm_grants,
  output logic [31:0]   stat_conflict
`endif
);

  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_lat_cnt;
  logic [CW-1:0] r_starve_cnt;
  logic          r_owner_dm;
  logic          r_if_ready;
  logic          r_dm_ready;

  logic w_starved;
  logic w_grant_dm;
  logic w_issue;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign w_starved  = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_grant_dm = dm_req & ~(if_req & w_starved);
  assign w_issue    = rst & (r_state == IDLE) & (if_req | dm_req);

  assign mem_en    = w_issue;
  assign mem_we    = w_issue & w_grant_dm & dm_we;
  assign mem_addr  = !w_issue ? '0 : (w_grant_dm ? dm_addr : if_addr);
  assign mem_wdata = mem_we ? dm_wdata : '0;

  assign if_ready   = r_if_ready;
  assign dm_ready   = r_dm_ready;
  assign if_rdata   = r_if_ready ? mem_rdata : '0;
  assign dm_rdata   = r_dm_ready ? mem_rdata : '0;
  assign stall_if   = if_req & ~r_if_ready;
  assign stall_pipe = dm_req & ~r_dm_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_owner_dm   <= 1'b0;
      r_if_ready   <= 1'b0;
      r_dm_ready   <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!if_req) r_starve_cnt <= '0;
          if (w_issue) begin
            r_owner_dm <= w_grant_dm;
            r_lat_cnt  <= CW'(1);
            if (!w_grant_dm)                 r_starve_cnt <= '0;
            else if (if_req && !w_starved)   r_starve_cnt <= r_starve_cnt + CW'(1);
            if (MEM_LAT == 1) begin
              r_state    <= DONE;
              r_if_ready <= ~w_grant_dm;
              r_dm_ready <= w_grant_dm;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_lat_cnt == CW'(MEM_LAT - 1)) begin
            r_state    <= DONE;
            r_if_ready <= ~r_owner_dm;
            r_dm_ready <= r_owner_dm;
          end else begin
            r_lat_cnt <= r_lat_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_lat_cnt <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] r_stat_if;
  logic [31:0] r_stat_dm;
  logic [31:0] r_stat_conf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_if   <= '0;
      r_stat_dm   <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_issue && !w_grant_dm)                     r_stat_if   <= r_stat_if + 32'd1;
      if (w_issue && w_grant_dm)                      r_stat_dm   <= r_stat_dm + 32'd1;
      if ((r_state == IDLE) && if_req && dm_req)      r_stat_conf <= r_stat_conf + 32'd1;
    end
  end

  assign stat_if_grants = r_stat_if;
  assign stat_dm_grants = r_stat_dm;
  assign stat_conflict  = r_stat_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences and a
// randomized run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: MEM_LAT=2, STARVE_MAX=3
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_pipe;

  // Second instance: MEM_LAT=1, fetch only
  logic        if_req1 = 1'b0;
  logic        dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [31:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_pipe1;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] stat_if_grants, stat_dm_grants, stat_conflict;
  logic [31:0] stat_if_grants1, stat_dm_grants1, stat_conflict1;
`endif

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants), .stat_conflict(stat_conflict)
`endif
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_pipe(stall_pipe1)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .stat_if_grants(stat_if_grants1), .stat_dm_grants(stat_dm_grants1), .stat_conflict(stat_conflict1)
`endif
  );

  // Behavioural memory: untouched words read as {C0DE, addr[15:0]}; data valid only LAT cycles after issue.
  logic [31:0] wr_mem [0:255];
  bit          wr_vld [0:255];
  logic [31:0] rd_pipe0, rd_pipe1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return wr_vld[a[9:2]] ? wr_mem[a[9:2]] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_mem[mem_addr[9:2]] <= mem_wdata;
      wr_vld[mem_addr[9:2]] <= 1'b1;
    end
    rd_pipe0   <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hBAD0_BAD0;
    rd_pipe1   <= rd_pipe0;
    mem_rdata1 <= (mem_en1 && !mem_we1) ? init_val(mem_addr1) : (32'hBAD1_0000 | mem_wdata1);
  end
  assign mem_rdata = rd_pipe1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_en"},     mem_en,     0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_if_ready"},   if_ready,   0);
    check({tag, "_dm_ready"},   dm_ready,   0);
    check({tag, "_if_rdata"},   if_rdata,   0);
    check({tag, "_dm_rdata"},   dm_rdata,   0);
    check({tag, "_stall_if"},   stall_if,   0);
    check({tag, "_stall_pipe"}, stall_pipe, 0);
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        exp_dm;
    logic        exp_we;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic        w_dm;
    logic [31:0] w_addr;

    vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b1, 32'hC0DE_0010};
    vt[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[3] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h44, 32'h0,         1'b1, 1'b0, 1'b1, 32'hC0DE_0044};
    vt[4] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};

    // Reset state
    next_cycle();
    next_cycle();
    #1;
    check_quiet("reset");
    check("reset_if_ready1", if_ready1, 0);
    check("reset_mem_en1",   mem_en1,   0);
`ifdef MEM_PORT_ARBITER_STATS_EN
    check("reset_stat_if",   stat_if_grants, 0);
    check("reset_stat_dm",   stat_dm_grants, 0);
    check("reset_stat_conf", stat_conflict,  0);
`endif
    next_cycle();
    rst = 1'b1;

    // Directed vector table: one access from IDLE each
    foreach (vt[i]) begin
      next_cycle();
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      dm_req = vt[i].dm_req; dm_we = vt[i].dm_we; dm_addr = vt[i].dm_addr; dm_wdata = vt[i].dm_wdata;
      w_dm   = vt[i].exp_dm;
      w_addr = w_dm ? vt[i].dm_addr : vt[i].if_addr;
      #1;
      check("vec_issue_mem_en", mem_en, 1);
      check("vec_issue_addr", mem_addr, w_addr);
      check("vec_issue_we", mem_we, vt[i].exp_we);
      if (vt[i].exp_we) check("vec_issue_wdata", mem_wdata, vt[i].dm_wdata);
      check("vec_issue_stall_if", stall_if, vt[i].if_req);
      check("vec_issue_stall_pipe", stall_pipe, vt[i].dm_req);
      check("vec_issue_if_ready", if_ready, 0);
      check("vec_issue_dm_ready", dm_ready, 0);

      next_cycle(); #1;
      check("vec_wait_mem_en", mem_en, 0);
      check("vec_wait_if_ready", if_ready, 0);
      check("vec_wait_dm_ready", dm_ready, 0);

      next_cycle(); #1;
      check("vec_done_mem_en", mem_en, 0);
      check("vec_done_if_ready", if_ready, !w_dm);
      check("vec_done_dm_ready", dm_ready, w_dm);
      check("vec_done_stall_if", stall_if, vt[i].if_req & w_dm);
      check("vec_done_stall_pipe", stall_pipe, vt[i].dm_req & !w_dm);
      if (vt[i].chk_rd) check("vec_done_rdata", w_dm ? dm_rdata : if_rdata, vt[i].exp_rd);
      check("vec_done_other_rdata", w_dm ? if_rdata : dm_rdata, 0);
      if (vt[i].exp_we) check("vec_store_committed", mem_val(vt[i].dm_addr), vt[i].dm_wdata);

      next_cycle();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      #1;
      check("vec_idle_mem_en", mem_en, 0);
    end

    // Both requesters held: data wins until fetch has waited STARVE_MAX grants
    begin
      int ng   = 0;
      int last = -1;
      for (int c = 0; c < 40 && ng < 8; c++) begin
        next_cycle();
        if (c == 0) begin
          if_req = 1'b1; if_addr = 32'h100;
          dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        end
        #1;
        if (mem_en) begin
          check("starve_grant_is_dm", mem_addr == 32'h200, (ng % (SMAX + 1)) != SMAX);
          if (ng > 0) check("starve_grant_spacing", c - last, LAT + 1);
          last = c;
          ng++;
        end
      end
      check("starve_grant_count", ng, 8);
      next_cycle();
      if_req = 1'b0; dm_req = 1'b0;
      repeat (3) next_cycle();
    end

    // MEM_LAT=1: back-to-back fetches
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (k == 0) begin if_req1 = 1'b1; if_addr1 = 32'h30; end
      #1;
      check("lat1_mem_en", mem_en1, (k % 2) == 0);
      check("lat1_if_ready", if_ready1, (k % 2) == 1);
      check("lat1_dm_ready", dm_ready1, 0);
      if (k % 2 == 1) check("lat1_if_rdata", if_rdata1, 32'hC0DE_0030);
      check("lat1_stall_pipe", stall_pipe1, 0);
      check("lat1_dm_rdata", dm_rdata1, 0);
    end
    next_cycle();
    if_req1 = 1'b0;
    repeat (2) next_cycle();

    // Data requester drops during WAIT; its ready still fires, then the pending fetch issues
    next_cycle();
    if_req = 1'b1; if_addr = 32'h24; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h28;
    #1;
    check("drop_issue_addr", mem_addr, 32'h28);
    next_cycle();
    dm_req = 1'b0;
    #1;
    check("drop_wait_stall_pipe", stall_pipe, 0);
    check("drop_wait_mem_en", mem_en, 0);
    next_cycle(); #1;
    check("drop_done_dm_ready", dm_ready, 1);
    check("drop_done_mem_en", mem_en, 0);
    check("drop_done_stall_if", stall_if, 1);
    next_cycle(); #1;
    check("drop_fetch_mem_en", mem_en, 1);
    check("drop_fetch_addr", mem_addr, 32'h24);
    check("drop_fetch_we", mem_we, 0);
    next_cycle();
    next_cycle(); #1;
    check("drop_fetch_ready", if_ready, 1);
    check("drop_fetch_rdata", if_rdata, 32'hC0DE_0024);
    next_cycle();
    if_req = 1'b0;
    repeat (2) next_cycle();

    // Reset during WAIT aborts the load
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
    #1;
    check("rstw_issue_mem_en", mem_en, 1);
    next_cycle();
    rst = 1'b0; dm_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    check_quiet("rstw_after");
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      check("rstw_no_dm_ready", dm_ready, 0);
    end
    next_cycle();
    dm_req = 1'b1;
    #1;
    check("rstw_new_issue", mem_en, 1);
    next_cycle();
    next_cycle(); #1;
    check("rstw_new_ready", dm_ready, 1);
    check("rstw_new_rdata", dm_rdata, 32'hC0DE_0048);
    next_cycle();
    dm_req = 1'b0;

    // Randomized traffic against a transaction-level model
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    begin
      int          done_at = -100;
      int          starve  = 0;
      logic        own_dm  = 1'b0;
      logic        own_st  = 1'b0;
      logic [31:0] exp_rd  = '0;
      logic [31:0] st_addr = '0, st_data = '0;
      logic        saw_if  = 1'b0, saw_dm = 1'b0;
      logic        e_if_rdy, e_dm_rdy, e_dm;
      int          m_if_g = 0, m_dm_g = 0, m_conf = 0;
      for (int k = 0; k < 800; k++) begin
        next_cycle();
        if (saw_if) if_req = 1'b0;
        if (saw_dm) dm_req = 1'b0;
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = {22'b0, 8'($urandom), 2'b00};
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = {22'b0, 8'($urandom), 2'b00}; dm_wdata = $urandom;
        end
        #1;
        e_if_rdy = (k == done_at) && !own_dm;
        e_dm_rdy = (k == done_at) && own_dm;
        check("rnd_if_ready", if_ready, e_if_rdy);
        check("rnd_dm_ready", dm_ready, e_dm_rdy);
        check("rnd_stall_if", stall_if, if_req & !e_if_rdy);
        check("rnd_stall_pipe", stall_pipe, dm_req & !e_dm_rdy);
        if (k == done_at) begin
          check("rnd_done_mem_en", mem_en, 0);
          if (own_st) check("rnd_store_committed", mem_val(st_addr), st_data);
          else check("rnd_rdata", own_dm ? dm_rdata : if_rdata, exp_rd);
          check("rnd_other_rdata", own_dm ? if_rdata : dm_rdata, 0);
        end else if (k < done_at) begin
          check("rnd_busy_mem_en", mem_en, 0);
        end else begin
          check("rnd_idle_mem_en", mem_en, if_req | dm_req);
          if (if_req && dm_req) m_conf++;
          if (if_req | dm_req) begin
            e_dm = dm_req && !(if_req && starve == SMAX);
            check("rnd_grant_addr", mem_addr, e_dm ? dm_addr : if_addr);
            check("rnd_grant_we", mem_we, e_dm & dm_we);
            if (e_dm && dm_we) check("rnd_grant_wdata", mem_wdata, dm_wdata);
            own_dm  = e_dm;
            own_st  = e_dm && dm_we;
            st_addr = dm_addr;
            st_data = dm_wdata;
            exp_rd  = mem_val(e_dm ? dm_addr : if_addr);
            done_at = k + LAT;
            if (e_dm) m_dm_g++; else m_if_g++;
          end
          if (!if_req || ((if_req | dm_req) && !e_dm)) starve = 0;
          else if (dm_req && starve < SMAX) starve++;
        end
        saw_if = e_if_rdy;
        saw_dm = e_dm_rdy;
      end
`ifdef MEM_PORT_ARBITER_STATS_EN
      #1;
      check("stat_if_grants", stat_if_grants, m_if_g);
      check("stat_dm_grants", stat_dm_grants, m_dm_g);
      check("stat_conflict",  stat_conflict,  m_conf);
`endif
    end
    next_cycle();
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the IF stage fetch and the MEM stage load/store (driven by MemRead/MemWrite).
- Sequences each memory access over a fixed latency and returns a one-cycle ready.
- Produces stall signals that freeze the pipeline until the owning requester is served.
- Data wins by default; an anti-starvation counter guarantees fetch progress.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from issue cycle to data-valid cycle; legal range 1..15.
- STARVE_MAX, 3, consecutive data grants that may be issued while fetch is pending before fetch is forced; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid only while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request (MemRead|MemWrite); held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; valid only while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data (loads and stores)
- mem_en  out  1  one-cycle issue strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  memory address, qualified by mem_en
- mem_wdata  out  DW  memory write data, qualified by mem_en
- mem_rdata  in  DW  memory read data; valid exactly MEM_LAT cycles after the mem_en cycle
- stall_if  out  1  freeze PC/IF-ID: if_req & ~if_ready
- stall_pipe  out  1  freeze whole pipeline: dm_req & ~dm_ready

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE; latency counter, starve counter and owner register are cleared.
  - All registered outputs are 0. mem_en, if_ready and dm_ready are 0 in the cycle after reset.
  - Reset during an access aborts it; no ready pulse is ever produced for the aborted access.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If any request is pending, the arbiter selects a winner and pulses mem_en combinationally in that same cycle, driving the winner's address, write enable and write data (mem_we=0 for fetch).
  - It latches the owner and goes to WAIT, or to DONE when MEM_LAT=1.
  - With no request pending it stays in IDLE with mem_en=0.
- WAIT: the counter increments each cycle; the FSM moves to DONE when the count reaches MEM_LAT-1.
- DONE:
  - Exactly MEM_LAT cycles after the issue cycle.
  - Pulses the owner's ready for one cycle; the owner's rdata = mem_rdata, while the other rdata = 0.
  - Returns to IDLE. The next issue occurs no earlier than the following cycle, so each access occupies MEM_LAT+1 cycles.
- Arbitration, evaluated in IDLE only:
  - Only dm_req: data wins. Only if_req: fetch wins.
  - Both pending: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments on each data grant issued while if_req=1 and saturates at STARVE_MAX. It clears on any fetch grant, and clears whenever if_req=0 in IDLE.
- Ready and stall:
  - Ready pulses never occur without a prior mem_en for that owner.
  - The stall outputs are combinational from req and ready and drop in the ready cycle.
- Requester rules:
  - Addresses and data must stay stable while the request is held.
  - If a requester drops its req mid-access, the memory access still completes and its ready pulse still fires; the requester ignores it.
  - A store's ready means the write has been committed.
- Simultaneous events:
  - A new req arriving during WAIT or DONE is not sampled until IDLE.
  - The ready pulse and a new issue never occur in the same cycle.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined, adds three output ports:
  - stat_if_grants [31:0], counting fetch grants.
  - stat_dm_grants [31:0], counting data grants.
  - stat_conflict [31:0], counting IDLE cycles in which both requests are pending.
- The counters clear on reset and wrap modulo 2^32.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- MEM_LAT=2; if_req=1, if_addr=0x10 at cycle 0 -> mem_en=1, mem_addr=0x10, mem_we=0 at cycle 0; if_ready=1 with if_rdata=mem_rdata at cycle 2; stall_if=1 in cycles 0-1.
- MEM_LAT=2; dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF at the issue cycle; dm_ready at +2; if_ready stays 0.
- if_req and dm_req both held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; every grant is separated by 3 cycles.
- MEM_LAT=1; back-to-back fetches -> mem_en on cycles 0,2,4 and if_ready on cycles 1,3,5.
- Reset asserted (rst=0) in WAIT cycle 1 of a load -> no dm_ready ever; all outputs 0 after the edge; a request issued after reset is served normally.
- dm_req dropped during WAIT -> dm_ready still pulses at issue+MEM_LAT; a pending fetch is issued the next cycle.
